fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin arbiter sharing the single write port of the async FIFO between `N_REQ` producers in the write clock domain. Drives `winc` and `wdata` into the write side of the FIFO, consumes its `wfull` flag, and returns a per-requester accept pulse. Optionally locks the grant for multi-beat bursts, and counts full-stall cycles for debug.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters; must be at least 2.
- `DWIDTH`, default 8: data width of each requester and of `wdata`.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `wclk`, input, 1: write-domain clock. One clock only; all logic is on `posedge wclk`.
- `wrst`, input, 1: reset, asynchronous, active-high.
- `req`, input, `N_REQ`: per-requester write request. Held, with data stable, until `wack`.
- `req_last`, input, `N_REQ`: marks the final beat of a burst. Used only with `FIFO_ARB_BURST_EN`.
- `req_data`, input, `N_REQ*DWIDTH`: packed data. Requester i occupies `[i*DWIDTH +: DWIDTH]`.
- `wfull`, input, 1: full flag from the FIFO write pointer logic, same cycle.
- `wack`, output, `N_REQ`: one-hot. Beat from requester i accepted this cycle.
- `winc`, output, 1: FIFO write increment.
- `wdata`, output, `DWIDTH`: FIFO write data.
- `gnt_vld`, output, 1: a grant is held.
- `gnt_id`, output, `$clog2(N_REQ)`: index of the granted requester.
- `stall_cnt`, output, `CNT_W`: saturating count of full-stalled cycles.

## Operation

- States are `IDLE` (no grant) and `BUSY` (grant held on `gnt_id`).
- A register `last_id` holds the most recent winner.
- Beat definition: `beat = gnt_vld & req[gnt_id] & ~wfull`.
  - `winc = beat`.
  - `wack = beat ? onehot(gnt_id) : 0`.
  - `wdata = req_data` slice selected by `gnt_id`, driven even when `winc` is 0.
- Round-robin pick: search from `last_id+1` upward, wrapping modulo `N_REQ`. The first set bit of the current `req` wins. This includes `last_id` itself as the lowest-priority candidate.
- `IDLE`:
  - If `|req` is set, go to `BUSY`, load `gnt_id` with the pick, set `gnt_vld`.
  - Otherwise stay in `IDLE`.
- `BUSY`, on a beat:
  - Set `last_id` to `gnt_id`.
  - Re-pick from the same-cycle `req` and load the new grant, which may equal the current one.
  - If the pick finds no request, go to `IDLE`.
- `BUSY`, no beat, `wfull=1`: hold the grant. No re-arbitration while full.
- `BUSY`, no beat, `req[gnt_id]=0` (requester withdrew): go to `IDLE` next cycle. `last_id` is unchanged.
- Stall counter: increments when `gnt_vld & req[gnt_id] & wfull`. Saturates at all-ones and never wraps.
- Reset values:
  - State `IDLE`, `gnt_vld=0`, `gnt_id=0`, `last_id=N_REQ-1` (so requester 0 wins first), `stall_cnt=0`.
  - `winc=0`, `wack=0`.
  - `wdata` follows `req_data[0 +: DWIDTH]`.

## Timing

- Latency from `req` rising in `IDLE` to the first `wack`: 1 cycle (grant registered at the next edge).
- Sustained throughput: 1 beat per cycle while any `req` is held and `wfull=0`. No bubble between grants in `BUSY`.
- `wfull` affects `winc` and `wack` combinationally in the same cycle.
- `wrst` asserted at any time clears all state immediately, without waiting for a clock edge. A beat presented in that cycle is not acknowledged.

## Configuration

- Macro: `FIFO_ARB_BURST_EN`.
- Defined:
  - A beat with `req_last[gnt_id]=0` keeps the grant on `gnt_id` with no re-pick; `last_id` is not updated.
  - A beat with `req_last=1` re-arbitrates as above.
  - Withdrawal mid-burst releases the grant, as in the non-burst case.
- Undefined: `req_last` is ignored. Every beat re-arbitrates.

## Structure

- Package `fifo_arb_pkg`:
  - State enum `arb_state_t` with values `IDLE` and `BUSY`.
  - Function `rr_next_idx(mask, last)`, used by both the RTL and the scoreboard.
- Sub-module `fifo_rr_pick`: combinational round-robin selector (`req` mask and `last_id` in; index and `found` out). It is instantiated once.

## Test plan

- **All requesting, non-burst:** `N_REQ=4`, `req=4'b1111` held, `wfull=0`, macro off. Grants run 0,1,2,3,0 on consecutive cycles from cycle 1; `winc` stays high every cycle from cycle 1.
- **Full stall:** with `req=4'b0100` granted, hold `wfull=1` for 3 cycles. `winc=0` and `wack=0` for 3 cycles, `gnt_id` stays 2, `stall_cnt` goes 0 to 3, and the beat is accepted on the cycle `wfull` falls.
- **Withdrawal:** while granted to requester 1 with `wfull=1`, drop `req[1]`. `gnt_vld=0` next cycle. A subsequent `req=4'b0011` is granted to 0 (since `last_id` is still 3).
- **Burst mode:** macro on. Requester 0 sends 3 beats with `req_last` on the third, requester 1 requesting throughout. Accepted sequence is 0,0,0,1.
- **Saturation:** `CNT_W=4`, 20 stalled cycles. `stall_cnt` reads 15 and holds there.
- **Reset mid-burst:** assert `wrst` between clock edges. `gnt_vld`, `winc`, `wack` and `stall_cnt` go to 0 before the next edge. After release with `req=4'b1111`, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned MAX_REQ = 32;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    // First set bit of mask searching upward from last+1, wrapping modulo n.
    // last itself is the lowest-priority candidate; returns last if mask is empty.
    function automatic int unsigned rr_next_idx(input logic [MAX_REQ-1:0] mask,
                                                input int unsigned         last,
                                                input int unsigned         n);
        int unsigned res;
        int unsigned idx;
        res = last;
        // Walk from lowest to highest priority so the final hit wins.
        for (int unsigned i = MAX_REQ; i > 0; i--) begin
            if (i <= n) begin
                idx = last + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (mask[idx]) begin
                    res = idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: request mask and previous winner in, next winner out.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  N_REQ = 4,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_id,
    output logic [IW-1:0]    idx,
    output logic             found
);

    always_comb begin
        found = |req;
        idx   = IW'(rr_next_idx(MAX_REQ'(req), 32'(last_id), N_REQ));
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between N_REQ producers.
// Define FIFO_ARB_BURST_EN to lock the grant until the beat flagged by req_last.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  N_REQ  = 4,
    parameter int unsigned  DWIDTH = 8,
    parameter int unsigned  CNT_W  = 16,
    localparam int unsigned IW     = $clog2(N_REQ)
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DWIDTH-1:0] req_data,
    input  logic                    wfull,
    output logic [N_REQ-1:0]        wack,
    output logic                    winc,
    output logic [DWIDTH-1:0]       wdata,
    output logic                    gnt_vld,
    output logic [IW-1:0]           gnt_id,
    output logic [CNT_W-1:0]        stall_cnt
);

    arb_state_t    state;
    logic [IW-1:0] last_id;
    logic [IW-1:0] pick_last;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          req_gnt;
    logic          beat;
    logic          stall;
    logic          rearb;

    always_comb begin
        req_gnt   = req[gnt_id];
        beat      = gnt_vld & req_gnt & ~wfull;
        stall     = gnt_vld & req_gnt & wfull;
        winc      = beat;
        wack      = beat ? (N_REQ'(1) << gnt_id) : '0;
        wdata     = req_data[gnt_id*DWIDTH +: DWIDTH];
        // On a beat the current grant becomes the new round-robin origin.
        pick_last = beat ? gnt_id : last_id;
`ifdef FIFO_ARB_BURST_EN
        rearb     = beat & req_last[gnt_id];
`else
        rearb     = beat;
`endif
    end

`ifndef FIFO_ARB_BURST_EN
    logic unused_req_last;
    assign unused_req_last = ^req_last;
`endif

    fifo_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req),
        .last_id (pick_last),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state     <= IDLE;
            gnt_vld   <= 1'b0;
            gnt_id    <= '0;
            last_id   <= IW'(N_REQ - 1);
            stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state   <= BUSY;
                        gnt_vld <= 1'b1;
                        gnt_id  <= pick_idx;
                    end
                end
                BUSY: begin
                    if (rearb) begin
                        last_id <= gnt_id;
                        if (pick_found) begin
                            gnt_id <= pick_idx;
                        end else begin
                            state   <= IDLE;
                            gnt_vld <= 1'b0;
                        end
                    end else if (!req_gnt) begin
                        // Requester withdrew: release without touching last_id.
                        state   <= IDLE;
                        gnt_vld <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
